// File: rtl/pipeline_pkg.sv
// Shared types for the memory port arbiter: FSM state and bus owner encodings.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters, with the fetch starvation counter.
module mem_arb_pick
    import pipeline_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arb_i,
    input  logic       if_req_raw_i,
    input  logic       if_req_i,
    input  logic       d_req_i,
    output arb_owner_e win_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    always_comb begin
        win_o = OWN_NONE;
        if (d_req_i && !(if_req_i && starve_q == CNT_MAX)) begin
            win_o = OWN_D;
        end else if (if_req_i) begin
            win_o = OWN_IF;
        end
    end

    // A fetch masked by a flush is not waiting, so a data win then does not count.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_raw_i) begin
            starve_d = '0;
        end else if (arb_i && win_o == OWN_IF) begin
            starve_d = '0;
        end else if (arb_i && win_o == OWN_D && if_req_i && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one outstanding transaction at a time.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ARB_IDLE | no transaction; a pending request is issued combinationally
//  ARB_REQ  | request raised, waiting for mem_ready_i
//  ARB_WAIT | request accepted, waiting for mem_rvalid_i
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    output logic                if_stall_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_valid_o,
    output logic                d_stall_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    arb_state_e state_q;
    arb_owner_e owner_q;
    logic       drop_q;

    arb_owner_e win;
    arb_owner_e sel;
    logic       in_idle;
    logic       if_req_eff;
    logic       flush_hit;
    logic       resp;

    assign in_idle    = (state_q == ARB_IDLE);
    assign if_req_eff = if_req_i & ~(in_idle & if_flush_i);
    assign flush_hit  = if_flush_i & (owner_q == OWN_IF);
    assign resp       = (state_q == ARB_WAIT) & mem_rvalid_i;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .arb_i        (in_idle),
        .if_req_raw_i (if_req_i),
        .if_req_i     (if_req_eff),
        .d_req_i      (d_req_i),
        .win_o        (win)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win != OWN_NONE) begin
                        owner_q <= win;
                        drop_q  <= 1'b0;
                        state_q <= mem_ready_i ? ARB_WAIT : ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (flush_hit) drop_q <= 1'b1;
                    if (mem_ready_i) state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= ARB_IDLE;
                        owner_q <= OWN_NONE;
                        drop_q  <= 1'b0;
                    end else if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // The winner drives the bus in IDLE; afterwards the latched owner keeps it.
    assign sel       = in_idle ? win : owner_q;
    assign mem_req_o = ~rst_i & ((in_idle & (win != OWN_NONE)) | (state_q == ARB_REQ));

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (mem_req_o) begin
            if (sel == OWN_D) begin
                mem_we_o    = d_we_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                mem_be_o    = d_be_i;
            end else begin
                mem_addr_o = if_addr_i;
                mem_be_o   = '1;
            end
        end
    end

    assign if_valid_o = resp & (owner_q == OWN_IF) & ~drop_q & ~if_flush_i;
    assign d_valid_o  = resp & (owner_q == OWN_D);
    assign if_rdata_o = if_valid_o ? mem_rdata_i : '0;
    assign d_rdata_o  = d_valid_o ? mem_rdata_i : '0;
    assign if_stall_o = if_req_i & ~if_valid_o;
    assign d_stall_o  = d_req_i & ~d_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, d_req, d_we, mem_ready, mem_rvalid;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [BW-1:0] d_be;
    logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
    logic          if_valid_o, if_stall_o, d_valid_o, d_stall_o, mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [BW-1:0] mem_be_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
        .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: who holds the bus, whether it was accepted,
    // whether a fetch was cancelled, and how long fetch has been waiting.
    bit m_busy, m_acc, m_cancel;
    int m_who;       // 1 = fetch, 2 = data
    int m_starve;
    int cur_win;
    bit got_ifv, got_dv;

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_cancel = 0; m_who = 0; m_starve = 0;
    endtask

    task automatic eval();
        bit e_req, e_ifv, e_dv, ifr;
        #1;
        if (rst) model_reset();
        e_req = 0; e_ifv = 0; e_dv = 0; cur_win = 0;
        if (!rst) begin
            if (!m_busy) begin
                ifr = if_req && !if_flush;
                if (d_req && !(ifr && m_starve == SMAX)) cur_win = 2;
                else if (ifr) cur_win = 1;
                e_req = (cur_win != 0);
            end else if (!m_acc) begin
                cur_win = m_who;
                e_req   = 1;
            end else if (mem_rvalid) begin
                e_ifv = (m_who == 1) && !m_cancel && !if_flush;
                e_dv  = (m_who == 2);
            end
        end
        chk("mem_req", mem_req_o, e_req);
        if (e_req) begin
            if (cur_win == 2) begin
                chk("mem_addr_d", mem_addr_o, d_addr);
                chk("mem_we_d", mem_we_o, d_we);
                chk("mem_wdata_d", mem_wdata_o, d_wdata);
                chk("mem_be_d", mem_be_o, d_be);
            end else begin
                chk("mem_addr_if", mem_addr_o, if_addr);
                chk("mem_we_if", mem_we_o, 0);
                chk("mem_be_if", mem_be_o, {BW{1'b1}});
            end
        end
        chk("if_valid", if_valid_o, e_ifv);
        chk("d_valid", d_valid_o, e_dv);
        if (e_ifv) chk("if_rdata", if_rdata_o, mem_rdata);
        if (e_dv) chk("d_rdata", d_rdata_o, mem_rdata);
        chk("if_stall", if_stall_o, if_req && !e_ifv);
        chk("d_stall", d_stall_o, d_req && !e_dv);
        chk("starve_cnt", dut.u_pick.starve_q, m_starve);
        got_ifv = e_ifv;
        got_dv  = e_dv;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!m_busy) begin
                if (cur_win != 0) begin
                    m_busy = 1; m_who = cur_win; m_acc = mem_ready; m_cancel = 0;
                    if (cur_win == 1) m_starve = 0;
                    else if (if_req && !if_flush && m_starve < SMAX) m_starve++;
                end
            end else begin
                if (m_who == 1 && if_flush) m_cancel = 1;
                if (!m_acc) begin
                    if (mem_ready) m_acc = 1;
                end else if (mem_rvalid) begin
                    m_busy = 0; m_cancel = 0;
                end
            end
            if (!if_req) m_starve = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        if_req = 0; d_req = 0; if_flush = 0;
        for (int k = 0; k < 8 && m_busy; k++) begin
            mem_ready = 1; mem_rvalid = m_busy && m_acc;
            eval(); step();
        end
        mem_ready = 0; mem_rvalid = 0;
        eval(); step();
    endtask

    initial begin
        int dg, dvc;
        bit if_won;
        rst = 1; if_req = 1; if_flush = 0; d_req = 0; d_we = 0; mem_ready = 0; mem_rvalid = 0;
        if_addr = 32'h100; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        model_reset(); got_ifv = 0; got_dv = 0; cur_win = 0;
        @(negedge clk);
        // reset: bus idle even though fetch is requesting, stall follows its equation
        eval();
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_if_stall", if_stall_o, 1);
        step();
        rst = 0;

        // fetch at minimum latency
        mem_ready = 1;
        eval(); chk("f_req", mem_req_o, 1); step();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
        eval();
        chk("f_valid", if_valid_o, 1);
        chk("f_rdata", if_rdata_o, 32'h00500093);
        chk("f_stall", if_stall_o, 0);
        step();
        drain();

        // starvation: data held continuously against a waiting fetch
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hf;
        dg = 0; if_won = 0;
        for (int k = 0; k < 24 && !if_won; k++) begin
            mem_ready = 1; mem_rvalid = m_busy && m_acc; mem_rdata = $urandom;
            eval();
            if (mem_req_o) begin
                if (mem_addr_o == 32'h300) dg++;
                else if_won = 1;
            end
            step();
        end
        chk("starve_dwins", dg, SMAX);
        chk("starve_ifwin", if_won, 1);
        #1 chk("starve_clr", dut.u_pick.starve_q, 0);
        drain();

        // store with ready delayed three cycles
        d_req = 1; d_we = 1; d_addr = 32'h7000; d_wdata = $urandom; d_be = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3); mem_rvalid = 0;
            eval();
            chk("st_req", mem_req_o, 1);
            chk("st_addr", mem_addr_o, 32'h7000);
            chk("st_be", mem_be_o, 4'b0011);
            step();
        end
        dvc = 0;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 0; mem_rvalid = m_busy && m_acc;
            eval();
            if (d_valid_o) dvc++;
            step();
            if (got_dv) d_req = 0;
        end
        chk("st_vcount", dvc, 1);
        drain();

        // flush coinciding with the response, then a fresh fetch
        if_req = 1; if_addr = 32'h400; mem_ready = 1;
        eval(); step();
        mem_ready = 0; mem_rvalid = 1; if_flush = 1; mem_rdata = 32'hdeadbeef;
        eval(); chk("fl_novalid", if_valid_o, 0); step();
        if_flush = 0; mem_rvalid = 0; mem_ready = 1; if_addr = 32'h404;
        eval(); chk("fl_newreq", mem_req_o, 1); chk("fl_addr", mem_addr_o, 32'h404); step();
        mem_ready = 0; mem_rvalid = 1;
        eval(); chk("fl_valid2", if_valid_o, 1); step();
        drain();

        // reset while waiting, then a stray response after release
        if_req = 1; if_addr = 32'h500; mem_ready = 1;
        eval(); step();
        rst = 1; mem_ready = 0; mem_rvalid = 0;
        eval(); chk("rw_mem_req", mem_req_o, 0); step();
        rst = 0; if_req = 0;
        eval(); step();
        mem_rvalid = 1;
        eval();
        chk("stray_ifv", if_valid_o, 0);
        chk("stray_dv", d_valid_o, 0);
        chk("stray_starve", dut.u_pick.starve_q, 0);
        step();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h600; mem_ready = 1;
        eval(); chk("post_rst_req", mem_req_o, 1); step();
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || got_ifv || if_flush) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & 32'hffff_fffc;
            end
            if (!d_req || got_dv) begin
                d_req   = $urandom_range(0, 1);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = BW'($urandom);
            end
            if_flush   = ($urandom_range(0, 15) == 0);
            mem_ready  = $urandom_range(0, 1);
            mem_rvalid = m_busy && m_acc && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            eval();
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
